// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational W-bit ALU between two requesters. Each requester
//   issues an operation with a valid/ready handshake. A round-robin grant picks
//   at most one operation per cycle. Its result and Zero flag are registered
//   into that requester's response slot, which holds them until accepted.
//
// Handshake rule (applies to every valid/ready pair on this block):
//   a transfer happens on a rising clk edge when valid and ready are both 1.
//   The producer keeps valid and its payload stable until that transfer.
//   valid must never depend combinationally on ready.
//   reqN_ready is combinational from reqN_valid and rspN_ready.
//
// Ports
//   clk, reset                  : clock, asynchronous active-high reset
//   req0_valid/ready/op/a/b     : requester 0 operation channel
//   req1_valid/ready/op/a/b     : requester 1 operation channel
//   rsp0_valid/ready/out/zero   : requester 0 response slot
//   rsp1_valid/ready/out/zero   : requester 1 response slot
module alu_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_out,
    output logic         rsp0_zero,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_out,
    output logic         rsp1_zero
);

    typedef enum logic [2:0] {
        OP_XOR  = 3'd0,
        OP_RXOR = 3'd1,
        OP_OR   = 3'd2,
        OP_BEQ  = 3'd3,
        OP_LAND = 3'd4,
        OP_MA   = 3'd5,
        OP_BS   = 3'd6,
        OP_ADDI = 3'd7
    } alu_op_t;

    // last_grant = 1 after reset so requester 0 wins the first contention.
    logic last_grant;

    logic free0, free1;
    logic elig0, elig1;
    logic grant0, grant1;

    // A slot is free when empty, or when its current result is being
    // consumed this same cycle (allows back-to-back issue).
    assign free0 = !rsp0_valid || rsp0_ready;
    assign free1 = !rsp1_valid || rsp1_ready;
    assign elig0 = req0_valid && free0 && !reset;
    assign elig1 = req1_valid && free1 && !reset;

    // Under contention the requester that was not granted last wins.
    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && (!elig0 || !last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Single shared ALU; operands come from whichever requester is granted.
    alu_op_t      alu_op;
    logic [W-1:0] alu_a, alu_b;
    logic [W-1:0] alu_out;
    logic         alu_zero;

    assign alu_op = alu_op_t'(grant1 ? req1_op : req0_op);
    assign alu_a  = grant1 ? req1_a : req0_a;
    assign alu_b  = grant1 ? req1_b : req0_b;

    always_comb begin
        alu_out  = '0;
        alu_zero = 1'b0;
        case (alu_op)
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_RXOR: alu_out = {{(W-1){1'b0}}, ^alu_b};
            OP_OR:   alu_out = alu_a | alu_b;
            OP_BEQ:  alu_zero = (alu_a == alu_b);
            OP_LAND: alu_out = alu_a & alu_b;
            OP_MA:   alu_out = '0;
            // B[2] picks direction, B[1:0] the distance.
            OP_BS:   alu_out = alu_b[2] ? (alu_a >> alu_b[1:0])
                                        : (alu_a << alu_b[1:0]);
            OP_ADDI: alu_out = alu_a + alu_b;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp0_out   <= '0;
            rsp0_zero  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_out   <= '0;
            rsp1_zero  <= 1'b0;
        end else begin
            if (grant0) begin
                rsp0_valid <= 1'b1;
                rsp0_out   <= alu_out;
                rsp0_zero  <= alu_zero;
            end else if (rsp0_ready) begin
                // Data is kept; only the valid flag drops.
                rsp0_valid <= 1'b0;
            end

            if (grant1) begin
                rsp1_valid <= 1'b1;
                rsp1_out   <= alu_out;
                rsp1_zero  <= alu_zero;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end

            if (grant0 || grant1) begin
                last_grant <= grant1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Bench for alu_arbiter (W = 8). Inputs are applied 1 ns after each rising
//   edge and outputs are sampled mid-cycle, then compared with a reference
//   model that keeps each response slot as plain variables and computes ALU
//   results with integer arithmetic.
module tb_alu_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_out, rsp1_out;
    logic         rsp0_zero, rsp1_zero;

    alu_arbiter #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_out   (rsp0_out),
        .rsp0_zero  (rsp0_zero),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_out   (rsp1_out),
        .rsp1_zero  (rsp1_zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus state ----------------
    logic         s_v[2];
    logic [2:0]   s_op[2];
    logic [W-1:0] s_a[2];
    logic [W-1:0] s_b[2];
    logic         s_rr[2];

    // ---------------- reference model ----------------
    logic         m_valid[2];
    logic [W-1:0] m_out[2];
    logic         m_zero[2];
    int           m_last;
    int           m_grant;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Result as {zero, out}, from the opcode table with integer arithmetic.
    function automatic logic [8:0] alu_ref(input int op, input int a, input int b);
        int ones;
        int s;
        int r;
        logic z;
        r = 0;
        z = 1'b0;
        case (op)
            0: r = a ^ b;
            1: begin
                ones = 0;
                for (int k = 0; k < 8; k++) ones += (b >> k) & 1;
                r = ones % 2;
            end
            2: r = a | b;
            3: begin r = 0; z = (a == b); end
            4: r = a & b;
            5: r = 0;
            6: begin
                s = b % 4;
                if ((b / 4) % 2 == 1) r = a / (2 ** s);
                else                  r = (a * (2 ** s)) % 256;
            end
            default: r = (a + b) % 256;
        endcase
        alu_ref = {z, r[7:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_out[i]   = '0;
            m_zero[i]  = 1'b0;
        end
        m_last = 1;
    endtask

    task automatic set_idle();
        for (int i = 0; i < 2; i++) begin
            s_v[i] = 1'b0; s_op[i] = '0; s_a[i] = '0; s_b[i] = '0; s_rr[i] = 1'b1;
        end
    endtask

    task automatic apply_inputs();
        req0_valid = s_v[0]; req0_op = s_op[0]; req0_a = s_a[0]; req0_b = s_b[0];
        req1_valid = s_v[1]; req1_op = s_op[1]; req1_a = s_a[1]; req1_b = s_b[1];
        rsp0_ready = s_rr[0];
        rsp1_ready = s_rr[1];
    endtask

    // One clock cycle: drive, sample mid-cycle, compare, advance the model.
    task automatic step();
        logic elig[2];
        logic [8:0] res;
        @(posedge clk);
        #1;
        apply_inputs();
        #3;
        for (int i = 0; i < 2; i++)
            elig[i] = s_v[i] && (!m_valid[i] || s_rr[i]);
        if (elig[0] && elig[1]) m_grant = 1 - m_last;
        else if (elig[0])       m_grant = 0;
        else if (elig[1])       m_grant = 1;
        else                    m_grant = -1;

        check("req0_ready", {31'd0, req0_ready}, {31'd0, m_grant == 0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, m_grant == 1});
        check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_valid[0]});
        check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_valid[1]});
        check("rsp0_out",   {24'd0, rsp0_out},   {24'd0, m_out[0]});
        check("rsp1_out",   {24'd0, rsp1_out},   {24'd0, m_out[1]});
        check("rsp0_zero",  {31'd0, rsp0_zero},  {31'd0, m_zero[0]});
        check("rsp1_zero",  {31'd0, rsp1_zero},  {31'd0, m_zero[1]});

        for (int i = 0; i < 2; i++) begin
            if (m_grant == i) begin
                res = alu_ref(int'(s_op[i]), int'(s_a[i]), int'(s_b[i]));
                m_out[i]   = res[7:0];
                m_zero[i]  = res[8];
                m_valid[i] = 1'b1;
                m_last     = i;
            end else if (s_rr[i]) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        s_v[i] = 1'b1; s_op[i] = op; s_a[i] = a; s_b[i] = b;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        set_idle();
        s_v[0] = 1'b1;
        s_v[1] = 1'b1;
        apply_inputs();
        model_reset();
        reset = 1'b1;

        // While reset is high no request may be accepted.
        #3;
        check("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        check("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("reset_rsp1_out",   {24'd0, rsp1_out},   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_idle();
        apply_inputs();
        step();
        step();

        // Single issue: XOR 0x5A ^ 0xFF.
        issue(0, 3'd0, 8'h5A, 8'hFF);
        step();
        set_idle();
        step();
        check("xor_out", {24'd0, rsp0_out}, 32'hA5);
        check("xor_valid", {31'd0, rsp0_valid}, 32'd1);
        step();
        check("xor_valid_clear", {31'd0, rsp0_valid}, 32'd0);

        // Contention: ADDI on req0, BEQ on req1, both held valid.
        issue(0, 3'd7, 8'hF0, 8'h20);
        issue(1, 3'd3, 8'h33, 8'h33);
        for (int k = 0; k < 6; k++) step();
        check("addi_out", {24'd0, rsp0_out}, 32'h10);
        check("beq_out",  {24'd0, rsp1_out}, 32'h00);
        check("beq_zero", {31'd0, rsp1_zero}, 32'd1);

        // Backpressure on slot 1 while req0 keeps issuing.
        s_rr[1] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            issue(0, 3'(k), 8'(k * 17), 8'(k + 3));
            step();
        end
        s_rr[1] = 1'b1;
        issue(1, 3'd2, 8'h0F, 8'hF0);
        step();
        step();
        s_v[1] = 1'b0;
        step();
        set_idle();
        step();

        // Shift and reduce ops.
        issue(0, 3'd6, 8'h81, 8'h05); step(); set_idle(); step();
        check("bs_right", {24'd0, rsp0_out}, 32'h40);
        issue(0, 3'd6, 8'h81, 8'h02); step(); set_idle(); step();
        check("bs_left", {24'd0, rsp0_out}, 32'h04);
        issue(1, 3'd1, 8'h00, 8'h07); step(); set_idle(); step();
        check("rxor", {24'd0, rsp1_out}, 32'h01);
        issue(1, 3'd5, 8'hFF, 8'hFF); step(); set_idle(); step();
        check("ma", {24'd0, rsp1_out}, 32'h00);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++) begin
                s_v[i]  = ($urandom_range(0, 3) != 0);
                s_op[i] = 3'($urandom_range(0, 7));
                s_a[i]  = 8'($urandom_range(0, 255));
                s_b[i]  = ($urandom_range(0, 7) == 0) ? s_a[i] : 8'($urandom_range(0, 255));
                s_rr[i] = ($urandom_range(0, 2) != 0);
            end
            step();
        end

        // Mid-operation asynchronous reset with a pending response.
        set_idle();
        s_rr[0] = 1'b0;
        issue(0, 3'd2, 8'h12, 8'h34);
        step();
        s_v[0] = 1'b0;
        step();
        check("pre_reset_valid", {31'd0, rsp0_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_valid", {31'd0, rsp0_valid}, 32'd0);
        check("async_reset_out",   {24'd0, rsp0_out},   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_idle();
        issue(0, 3'd7, 8'h01, 8'h02);
        issue(1, 3'd7, 8'h03, 8'h04);
        step();
        check("post_reset_grant0", {31'd0, req0_ready}, 32'd1);
        step();
        check("post_reset_grant1", {31'd0, req1_ready}, 32'd1);
        set_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
